// File: rtl/regfile_mp.sv
// Multi-read-port register file with registered reads, optional write bypass,
// optional hardwired zero register and a per-register pending scoreboard.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned NUM_RD   = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_RD-1:0]      rd_en,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic                   sb_set,
    input  logic [AW-1:0]          sb_addr
);
    localparam int unsigned NumAddr = 2 ** AW;

    // One bit per encodable address: set where the address names a real,
    // writable register (in range and not the hardwired zero).
    function automatic logic [NumAddr-1:0] live_map();
        logic [NumAddr-1:0] m;
        m = '0;
        for (int unsigned a = 0; a < DEPTH; a++) m[a] = 1'b1;
        if (ZERO_REG) m[0] = 1'b0;
        return m;
    endfunction

    localparam logic [NumAddr-1:0] LiveMap = live_map();

    logic [XLEN-1:0]        mem_q [DEPTH];
    logic [DEPTH-1:0]       pend_q, pend_d;
    logic [NUM_RD*XLEN-1:0] rd_data_d;
    logic [NUM_RD-1:0]      rd_busy_d;
    logic                   wr_ok, sb_ok;

    assign wr_ok = wr_en & LiveMap[wr_addr];
    assign sb_ok = sb_set & LiveMap[sb_addr];

    // Set after clear: a newly issued producer outranks the retiring one.
    always_comb begin
        pend_d = pend_q;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            if (wr_ok && (wr_addr == AW'(a))) pend_d[a] = 1'b0;
            if (sb_ok && (sb_addr == AW'(a))) pend_d[a] = 1'b1;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        ra        = '0;
        rd_data_d = rd_data;
        rd_busy_d = rd_busy;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (rd_en[i]) begin
                ra = rd_addr[i*AW +: AW];
                if (BYPASS && wr_ok && (wr_addr == ra)) begin
                    rd_data_d[i*XLEN +: XLEN] = wr_data;
                    rd_busy_d[i]              = sb_ok && (sb_addr == ra);
                end else if (LiveMap[ra]) begin
                    rd_data_d[i*XLEN +: XLEN] = mem_q[ra];
                    rd_busy_d[i]              = pend_q[ra];
                end else begin
                    rd_data_d[i*XLEN +: XLEN] = '0;
                    rd_busy_d[i]              = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned a = 0; a < DEPTH; a++) mem_q[a] <= '0;
            pend_q  <= '0;
            rd_data <= '0;
            rd_busy <= '0;
        end else begin
            if (wr_ok) mem_q[wr_addr] <= wr_data;
            pend_q  <= pend_d;
            rd_data <= rd_data_d;
            rd_busy <= rd_busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations driven by one stimulus stream and
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_regfile_mp;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   rd_en;
    logic [14:0]  ra;
    logic         wr_en;
    logic [4:0]   wa;
    logic [63:0]  wd;
    logic         sb_set;
    logic [4:0]   sa;

    logic [63:0]  d0_data;
    logic [1:0]   d0_busy;
    logic [63:0]  d1_data;
    logic [1:0]   d1_busy;
    logic [191:0] d2_data;
    logic [2:0]   d2_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en[1:0]), .rd_addr(ra[9:0]),
        .rd_data(d0_data), .rd_busy(d0_busy), .wr_en(wr_en), .wr_addr(wa),
        .wr_data(wd[31:0]), .sb_set(sb_set), .sb_addr(sa)
    );

    regfile_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u_alt (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en[1:0]), .rd_addr(ra[9:0]),
        .rd_data(d1_data), .rd_busy(d1_busy), .wr_en(wr_en), .wr_addr(wa),
        .wr_data(wd[31:0]), .sb_set(sb_set), .sb_addr(sa)
    );

    regfile_mp #(.XLEN(64), .DEPTH(24), .NUM_RD(3)) u_wide (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(ra),
        .rd_data(d2_data), .rd_busy(d2_busy), .wr_en(wr_en), .wr_addr(wa),
        .wr_data(wd), .sb_set(sb_set), .sb_addr(sa)
    );

    // Model state, indexed [config][register] / [config][port].
    logic [63:0] m_mem  [3][32];
    logic        m_pend [3][32];
    logic [63:0] e_data [3][3];
    logic        e_busy [3][3];

    function automatic int cfg_depth(input int c); return (c == 2) ? 24 : 32; endfunction
    function automatic bit cfg_zero(input int c);  return c != 1;            endfunction
    function automatic bit cfg_byp(input int c);   return c != 1;            endfunction
    function automatic int cfg_nrd(input int c);   return (c == 2) ? 3 : 2;  endfunction
    function automatic logic [63:0] cfg_mask(input int c);
        return (c == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int a = 0; a < 32; a++) begin
                m_mem[c][a]  = '0;
                m_pend[c][a] = 1'b0;
            end
            for (int p = 0; p < 3; p++) begin
                e_data[c][p] = '0;
                e_busy[c][p] = 1'b0;
            end
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            int depth;
            bit zr, wv, sv;
            logic [4:0] a;
            depth = cfg_depth(c);
            zr = cfg_zero(c);
            wv = wr_en && (int'(wa) < depth) && !(zr && wa == 5'd0);
            sv = sb_set && (int'(sa) < depth) && !(zr && sa == 5'd0);
            for (int p = 0; p < cfg_nrd(c); p++) begin
                if (rd_en[p]) begin
                    a = ra[p*5 +: 5];
                    if (int'(a) >= depth || (zr && a == 5'd0)) begin
                        e_data[c][p] = '0;
                        e_busy[c][p] = 1'b0;
                    end else if (cfg_byp(c) && wv && wa == a) begin
                        e_data[c][p] = wd & cfg_mask(c);
                        e_busy[c][p] = sv && (sa == a);
                    end else begin
                        e_data[c][p] = m_mem[c][a];
                        e_busy[c][p] = m_pend[c][a];
                    end
                end
            end
            if (wv) begin
                m_mem[c][wa]  = wd & cfg_mask(c);
                m_pend[c][wa] = 1'b0;
            end
            if (sv) m_pend[c][sa] = 1'b1;
        end
    endtask

    function automatic logic [63:0] act_data(input int c, input int p);
        case (c)
            0:       return 64'(d0_data[p*32 +: 32]);
            1:       return 64'(d1_data[p*32 +: 32]);
            default: return d2_data[p*64 +: 64];
        endcase
    endfunction

    function automatic logic act_busy(input int c, input int p);
        case (c)
            0:       return d0_busy[p];
            1:       return d1_busy[p];
            default: return d2_busy[p];
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step();
            #1;
            for (int c = 0; c < 3; c++) begin
                for (int p = 0; p < cfg_nrd(c); p++) begin
                    check($sformatf("cfg%0d port%0d data", c, p), act_data(c, p), e_data[c][p]);
                    check($sformatf("cfg%0d port%0d busy", c, p),
                          64'(act_busy(c, p)), 64'(e_busy[c][p]));
                end
            end
        end
    end

    task automatic drive(input logic [2:0] re, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] a2, input logic we, input logic [4:0] w_a,
                         input logic [63:0] w_d, input logic s, input logic [4:0] s_a);
        rd_en  = re;
        ra     = {a2, a1, a0};
        wr_en  = we;
        wa     = w_a;
        wd     = w_d;
        sb_set = s;
        sa     = s_a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
    endtask

    function automatic logic [4:0] pick();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'($urandom_range(1, 4));
            2:       return 5'($urandom_range(20, 31));
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [4:0] pick_or(input logic [4:0] w);
        return ($urandom_range(0, 2) == 0) ? w : pick();
    endfunction

    localparam logic [63:0] Big = 64'h0123_4567_89AB_CDEF;

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset contents read back as zero.
        drive(3'b011, 5'd3, 5'd5, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        step();
        check("reset read data", d0_data, 64'h0);
        check("reset read busy", 64'(d0_busy), 64'h0);

        // One-cycle latency and hold while disabled.
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 64'hDEAD_BEEF, 1'b0, 5'd0);
        step();
        drive(3'b001, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        step();
        check("r7 read", 64'(d0_data[31:0]), 64'hDEAD_BEEF);
        check("model r7", e_data[0][0], 64'hDEAD_BEEF);
        drive(3'b000, 5'd7, 5'd0, 5'd0, 1'b1, 5'd7, 64'h1, 1'b0, 5'd0);
        step();
        check("r7 hold", 64'(d0_data[31:0]), 64'hDEAD_BEEF);

        // Zero register: hardwired in u_dut, ordinary in u_alt.
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 64'hFFFF_FFFF, 1'b0, 5'd0);
        step();
        drive(3'b111, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        step();
        check("r0 hardwired", d0_data, 64'h0);
        check("r0 writable", d1_data, 64'hFFFF_FFFF_FFFF_FFFF);

        // Bypass versus pre-write value.
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 64'h11, 1'b0, 5'd0);
        step();
        drive(3'b001, 5'd4, 5'd0, 5'd0, 1'b1, 5'd4, 64'h22, 1'b0, 5'd0);
        step();
        check("bypass on", 64'(d0_data[31:0]), 64'h22);
        check("bypass off", 64'(d1_data[31:0]), 64'h11);
        drive(3'b001, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        step();
        check("bypass off later", 64'(d1_data[31:0]), 64'h22);

        // Scoreboard set, clear by write, set-wins-over-clear.
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9);
        step();
        drive(3'b001, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        step();
        check("r9 pending", 64'(d0_busy[0]), 64'h1);
        check("model r9 pending", 64'(e_busy[0][0]), 64'h1);
        drive(3'b001, 5'd9, 5'd0, 5'd0, 1'b1, 5'd9, 64'h55, 1'b0, 5'd0);
        step();
        check("r9 bypass data", 64'(d0_data[31:0]), 64'h55);
        check("r9 bypass busy", 64'(d0_busy[0]), 64'h0);
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 64'h66, 1'b1, 5'd9);
        step();
        drive(3'b001, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        step();
        check("r9 set wins", 64'(d0_busy[0]), 64'h1);

        // Wide configuration: all ports agree, out-of-range is inert.
        drive(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd23, Big, 1'b0, 5'd0);
        step();
        drive(3'b111, 5'd23, 5'd23, 5'd23, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        step();
        check("wide port0", d2_data[63:0], Big);
        check("wide port1", d2_data[127:64], Big);
        check("wide port2", d2_data[191:128], Big);
        drive(3'b111, 5'd30, 5'd30, 5'd30, 1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd30);
        step();
        check("wide oor data", d2_data, 192'h0);
        check("wide oor busy", 64'(d2_busy), 64'h0);
        drive(3'b001, 5'd23, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0);
        step();
        check("wide r23 intact", d2_data[63:0], Big);

        // Asynchronous clear between edges.
        idle();
        #2 rst_n = 1'b0;
        #1;
        check("async clr d0", d0_data, 64'h0);
        check("async clr d2", d2_data[63:0], 64'h0);
        check("async clr busy", 64'({d0_busy, d1_busy}), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomised traffic with collisions and occasional mid-run resets.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] w;
            w = pick();
            drive(3'($urandom), pick_or(w), pick_or(w), pick_or(w), 1'($urandom_range(0, 1)), w,
                  {$urandom, $urandom}, ($urandom_range(0, 3) == 0), pick_or(w));
            step();
            if ((n % 600) == 599) begin
                #2 rst_n = 1'b0;
                #1;
                check("rand async clr", d0_data ^ d1_data, 64'h0);
                check("rand async clr wide", d2_data[63:0], 64'h0);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        idle();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
